// File: rtl/arbiter_rr4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM encoding, requester geometry and the rotating-priority scan.
package arbiter_rr4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Lowest offset from ptr wins, so the loop runs downward and the last hit is kept.
  function automatic logic [IDX_W-1:0] rr_scan(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_scan = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) begin
        rr_scan = idx;
      end else begin
        rr_scan = rr_scan;
      end
    end
  endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Enable-gated 2-to-4 one-hot decoder; output is all-zero when disabled.
module decoder_2to4 (
  input  logic       En,
  input  logic [1:0] a,
  output logic [3:0] d
);

  // One-hot decode of a, forced to zero while En is low
  always_comb begin
    d = 4'b0000;
    if (En) begin
      case (a)
        2'd0:    d = 4'b0001;
        2'd1:    d = 4'b0010;
        2'd2:    d = 4'b0100;
        2'd3:    d = 4'b1000;
        default: d = 4'b0000;
      endcase
    end else begin
      d = 4'b0000;
    end
  end

endmodule

// File: rtl/arbiter_rr4.sv
// Four-way round-robin arbiter with a bounded hold time per grant and a
// mandatory dead cycle between grants. All outputs come from registers.
module arbiter_rr4
  import arbiter_rr4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [IDX_W-1:0] ptr_r, ptr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             timeout_r, timeout_s;

  // State, grantee, pointer, hold counter and timeout pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= 2'd0;
      ptr_r     <= 2'd0;
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
      timeout_r <= timeout_s;
    end
  end

  // Next-state logic; request or enable loss outranks hold expiry for the pulse
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (En && (|req)) begin
          state_s = ST_GRANT;
          idx_s   = rr_scan(req, ptr_r);
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[idx_r] || !En) begin
          state_s = ST_IDLE;
          ptr_s   = idx_r + 2'd1;
        end else if (cnt_r == HOLD_LAST) begin
          state_s   = ST_IDLE;
          ptr_s     = idx_r + 2'd1;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign gnt_valid = (state_r == ST_GRANT);
  assign gnt_idx   = idx_r;
  assign timeout   = timeout_r;

  decoder_2to4 u_dec (
    .En (gnt_valid),
    .a  (idx_r),
    .d  (gnt)
  );

endmodule

// File: tb/tb_arbiter_rr4.sv
// Directed self-checking bench for arbiter_rr4 (MAX_HOLD=4); each task
// drives one scenario and compares outputs against hand-computed values.
module tb_arbiter_rr4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       En;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  arbiter_rr4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .En        (En),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; En = 1'b1; req = 4'b1111;
    tick(); tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt got %b want 0000", gnt); end
    n_cmp++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", gnt_valid); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b want 0", timeout); end
    n_cmp++; if (gnt_idx !== 2'b00) begin n_fail++; $display("FAIL rst_idx got %b want 00", gnt_idx); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_first_gnt got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
    n_cmp++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin n_fail++; $display("FAIL rst_release got %b/%b want 0000/0", gnt, timeout); end
  endtask

  // ptr=1 on entry
  task automatic test_single();
    req = 4'b0100;
    tick();
    n_cmp++; if (gnt !== 4'b0100 || gnt_idx !== 2'b10) begin n_fail++; $display("FAIL single_gnt got %b/%b want 0100/10", gnt, gnt_idx); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_hold%0d got %b want 0100", k, gnt); end
    end
    req = 4'b0000;
    tick();
    n_cmp++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b/%b want 0000/0", gnt, timeout); end
    n_cmp++; if (gnt_idx !== 2'b10) begin n_fail++; $display("FAIL single_idx_hold got %b want 10", gnt_idx); end
    req = 4'b1100;
    tick();
    n_cmp++; if (gnt !== 4'b1000 || gnt_idx !== 2'b11) begin n_fail++; $display("FAIL single_ptr3 got %b/%b want 1000/11", gnt, gnt_idx); end
    req = 4'b0000;
    tick();
  endtask

  // ptr=0 on entry
  task automatic test_rotation();
    logic [3:0] exp;
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      exp = 4'b0001 << g;
      for (int k = 0; k < 4; k++) begin
        tick();
        n_cmp++; if (gnt !== exp || timeout !== 1'b0) begin n_fail++; $display("FAIL rot_g%0d_c%0d got %b/%b want %b/0", g, k, gnt, timeout, exp); end
      end
      tick();
      n_cmp++; if (gnt !== 4'b0000 || timeout !== 1'b1) begin n_fail++; $display("FAIL rot_dead%0d got %b/%b want 0000/1", g, gnt, timeout); end
    end
    tick();
    n_cmp++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin n_fail++; $display("FAIL rot_wrap got %b/%b want 0001/0", gnt, timeout); end
    req = 4'b0000;
    tick();
  endtask

  // ptr=1 on entry
  task automatic test_wrap();
    req = 4'b0010;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL wrap_g1 got %b want 0010", gnt); end
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_ptr2 got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_g3 got %b want 1000", gnt); end
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_ptr0 got %b want 0001", gnt); end
    req = 4'b0000;
    tick();
  endtask

  // ptr=1 on entry
  task automatic test_enable();
    En = 1'b0; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL en_off%0d got %b want 0000", k, gnt); end
    end
    En = 1'b1;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL en_on got %b want 0010", gnt); end
    tick();
    En = 1'b0;
    tick();
    n_cmp++; if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_idx !== 2'b01) begin n_fail++; $display("FAIL en_drop got %b/%b/%b want 0000/0/01", gnt, timeout, gnt_idx); end
    En = 1'b1;
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL en_ptr_adv got %b want 0100", gnt); end
    req = 4'b0000;
    tick();
  endtask

  // ptr=3 on entry
  task automatic test_reset_mid();
    req = 4'b0010;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rmid_gnt got %b want 0010", gnt); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_idx !== 2'b00) begin n_fail++; $display("FAIL rmid_rst got %b/%b/%b want 0000/0/00", gnt, timeout, gnt_idx); end
    rst_n = 1'b1; req = 4'b1010;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rmid_ptr0 got %b want 0010", gnt); end
  endtask

  // Continues the grant to 1 from test_reset_mid; req drops exactly at expiry
  task automatic test_timeout_precedence();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL prec_hold%0d got %b want 0010", k, gnt); end
    end
    req = 4'b1000;
    tick();
    n_cmp++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin n_fail++; $display("FAIL prec_no_pulse got %b/%b want 0000/0", gnt, timeout); end
    tick();
    n_cmp++; if (gnt !== 4'b1000 || timeout !== 1'b0) begin n_fail++; $display("FAIL prec_next got %b/%b want 1000/0", gnt, timeout); end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; En = 1'b0; req = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_enable();
    test_reset_mid();
    test_timeout_precedence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_rr4.md
Name: arbiter_rr4

Overview:
- Four-requester round-robin arbiter that shares one resource slot between requesters 0..3.
- Encodes the winning index into a 2-bit grant index. Drives the one-hot grant through a 2-to-4 enable-gated decoder.
- Bounds each tenure with a hold timeout.
- Sits between requesting blocks and the shared resource's select lines.

Parameters:
MAX_HOLD, 16, max consecutive cycles one grant may stay asserted; legal range 1..255
CNT_W, 8, hold counter width; must satisfy MAX_HOLD <= 2^CNT_W - 1

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
En  input  1  global arbitration enable; 0 blocks new grants and forces release
req  input  4  request vector, bit i = requester i
gnt  output  4  one-hot grant (or 4'b0000), decoded from gnt_idx gated by gnt_valid
gnt_idx  output  2  encoded index of current grantee
gnt_valid  output  1  a grant is active
timeout  output  1  one-cycle pulse, high in the cycle after a release caused by MAX_HOLD expiry

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, gnt_valid=0, gnt=0000, gnt_idx=00, timeout=0, hold_cnt=0, ptr=0.
  - Applies mid-grant too: the grant drops at that edge and no timeout pulse is produced.
- State IDLE:
  - Entry condition: En=1 and |req.
  - Winner = first set bit of req scanned ptr, ptr+1, ... mod 4.
  - At the next edge: state=GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Latency: req to gnt is 1 cycle.
  - If En=0 or req=0000, stay IDLE; ptr is unchanged.
- State GRANT:
  - Release is evaluated at each edge. Release if any of:
    - req[gnt_idx]=0
    - En=0
    - hold_cnt==MAX_HOLD-1
  - Otherwise hold_cnt increments.
  - On release, next state=IDLE, gnt_valid=0, gnt=0000, and ptr=gnt_idx+1 (3 wraps to 0).
  - timeout=1 for exactly one cycle only when the release was due to hold_cnt==MAX_HOLD-1 while req[gnt_idx]=1 and En=1. Request or En loss takes precedence: no timeout pulse if req drop or En=0 coincides with expiry.
- Handover: one mandatory dead cycle (gnt=0000) between any two grants, so grants never overlap and can never be back-to-back without a gap.
- Hold limit: a requester holding req continuously sees gnt high for exactly MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts one cycle.
- Re-grant: a timed-out requester still requesting is re-granted only if no other requester is found first from the new ptr. If it is alone, it is re-granted after the dead cycle.
- During GRANT, changes on other req bits are ignored; only req[gnt_idx] is observed.
- Output timing: gnt, gnt_idx, gnt_valid and timeout are derived only from registers, with no combinational path from req or En.
- Invariant: gnt is always one-hot or zero.
- gnt_idx holds its last value while gnt_valid=0.

Decomposition:
- Shared include arb_defs.vh:
  - localparams ST_IDLE=1'b0, ST_GRANT=1'b1, N_REQ=4, IDX_W=2.
  - Round-robin scan function (req, ptr) -> winner index.
- One sub-module: instantiate the existing decoder_2to4 (ports En, a, d) with En=gnt_valid, a=gnt_idx, d=gnt.
- Everything else (FSM, ptr, hold_cnt, timeout) lives in arbiter_rr4.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with En=1, req=1111 -> gnt=0000, gnt_valid=0, timeout=0, gnt_idx=00. Release rst_n -> gnt=0001 at the following edge.
2. Single requester (MAX_HOLD=16): En=1, req=0100 -> gnt=0100, gnt_idx=10 one edge later. Drop req after 3 grant cycles -> gnt=0000 at next edge, timeout=0. Then req=1100 -> gnt=1000 (ptr=3).
3. Full-load rotation (MAX_HOLD=4): req=1111 held -> sequence 0001 x4, 0000, 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, 0001. timeout pulses in each dead cycle.
4. Wrap priority: grant to 1 released by req drop (ptr=2), then req=0011 -> grant 0. Grant to 3 released, then req=1001 -> grant 0.
5. Enable: En=0 with req=1111 for 5 cycles -> gnt stays 0000. En falls mid-grant -> gnt=0000 next edge, timeout=0, ptr advanced.
6. Reset mid-grant: gnt=0010 active, rst_n=0 one edge -> gnt=0000 at that edge, ptr=0. Then req=1010 -> gnt=0010.
